// File: rtl/compass_pkg.sv
`default_nettype none
// ============================================================================
// Module   : compass_pkg
// Brief    : Shared direction codes and sequence-state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package compass_pkg;

    localparam int dir_width_c = 2;

    typedef enum logic [1:0] {
        N = 2'b00,
        E = 2'b01,
        W = 2'b10,
        S = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        FILLING = 2'b01,
        ARMED   = 2'b10
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : hold_timer
// Brief    : Saturating counter; down mode loads load_p, up mode counts to it.
// Revision : 1.0 - initial release
// ============================================================================
module hold_timer
    import compass_pkg::*;
#(
    parameter int width_p    = 4,
    parameter int load_p     = 8,
    parameter bit count_up_p = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    output logic [width_p-1:0] count_o,
    output logic               busy_o
);

    localparam logic [width_p-1:0] c_load = width_p'(load_p);

    logic [width_p-1:0] r_count;

    generate
        if (count_up_p) begin : g_up
            // start_i restarts from zero; the count parks at load_p
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_count <= '0;
                end else if (start_i) begin
                    r_count <= '0;
                end else if (r_count != c_load) begin
                    r_count <= r_count + 1'b1;
                end
            end
            assign busy_o = (r_count != c_load);
        end else begin : g_down
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    r_count <= '0;
                end else if (start_i) begin
                    r_count <= c_load;
                end else if (r_count != '0) begin
                    r_count <= r_count - 1'b1;
                end
            end
            assign busy_o = (r_count != '0);
        end
    endgenerate

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/compass_seq_n.sv
`default_nettype none
// ============================================================================
// Module   : compass_seq_n
// Brief    : Loadable depth_p-entry direction sequence detector with win hold.
// Revision : 1.0 - initial release
// ============================================================================
module compass_seq_n
    import compass_pkg::*;
#(
    parameter int depth_p   = 4,
    parameter int timeout_p = 24000000,
    parameter int hold_p    = 12000000,
    parameter int overlap_p = 1,
    parameter logic [dir_width_c*depth_p-1:0] pattern_reset_p = '0
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [dir_width_c-1:0]             direction_i,
    input  logic                               valid_i,
    input  logic                               load_i,
    input  logic [dir_width_c*depth_p-1:0]     pattern_i,
    output logic                               detect_o,
    output logic                               win_o,
    output logic [$clog2(depth_p+1)-1:0]       fill_o,
    output logic                               timeout_o
);

    localparam int                  c_win_w  = dir_width_c * depth_p;
    localparam int                  c_fill_w = $clog2(depth_p + 1);
    localparam int                  c_hold_w = $clog2(hold_p + 1);
    localparam logic [c_fill_w-1:0] c_depth  = c_fill_w'(depth_p);

    logic [c_win_w-1:0]  r_window;
    logic [c_win_w-1:0]  r_pattern;
    logic [c_fill_w-1:0] r_fill;
    seq_state_t          r_state;
    logic                r_detect;
    logic                r_timeout;

    logic [c_win_w-1:0]  w_window_shift;
    logic [c_fill_w-1:0] w_fill_inc;
    logic [c_fill_w-1:0] w_fill_next;
    seq_state_t          w_state_next;
    logic                w_accept;
    logic                w_match;
    logic                w_timeout_fire;
    logic [c_hold_w-1:0] w_hold_count_unused;

    // load_i owns the cycle: a coincident strobe is dropped
    assign w_accept = valid_i && !load_i;

    generate
        if (depth_p == 1) begin : g_single
            assign w_window_shift = direction_i;
        end else begin : g_multi
            assign w_window_shift = {direction_i, r_window[c_win_w-1:dir_width_c]};
        end

        if (timeout_p > 0) begin : g_timeout
            localparam int                  c_idle_w    = $clog2(timeout_p + 1);
            localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(timeout_p - 1);

            logic [c_idle_w-1:0] w_idle_count;
            logic                w_idle_busy_unused;

            hold_timer #(
                .width_p    (c_idle_w),
                .load_p     (timeout_p),
                .count_up_p (1'b1)
            ) u_idle_timer (
                .clk_i     (clk_i),
                .reset_n_i (reset_n_i),
                .start_i   (valid_i || load_i || w_timeout_fire),
                .count_o   (w_idle_count),
                .busy_o    (w_idle_busy_unused)
            );

            // fires on the edge that would take the idle count to timeout_p
            assign w_timeout_fire = !valid_i && !load_i && (r_state != EMPTY)
                                    && (w_idle_count == c_idle_last);
        end else begin : g_no_timeout
            assign w_timeout_fire = 1'b0;
        end
    endgenerate

    always_comb begin
        w_fill_inc   = (r_state == ARMED) ? r_fill : r_fill + 1'b1;
        w_match      = w_accept && (w_fill_inc == c_depth) && (w_window_shift == r_pattern);
        w_fill_next  = r_fill;
        w_state_next = r_state;

        if (load_i) begin
            w_fill_next = '0;
        end else if (w_accept) begin
            w_fill_next = (w_match && (overlap_p == 0)) ? '0 : w_fill_inc;
        end else if (w_timeout_fire) begin
            w_fill_next = '0;
        end

        if (w_fill_next == '0) begin
            w_state_next = EMPTY;
        end else if (w_fill_next == c_depth) begin
            w_state_next = ARMED;
        end else begin
            w_state_next = FILLING;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_window  <= '0;
            r_pattern <= pattern_reset_p;
            r_fill    <= '0;
            r_detect  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_fill    <= w_fill_next;
            r_detect  <= w_match;
            r_timeout <= w_timeout_fire;
            if (load_i) begin
                r_pattern <= pattern_i;
                r_window  <= '0;
            end else if (w_accept) begin
                r_window  <= w_window_shift;
            end
        end
    end

    // loads on the same edge that raises detect_o, so win_o rises with it
    hold_timer #(
        .width_p    (c_hold_w),
        .load_p     (hold_p),
        .count_up_p (1'b0)
    ) u_win_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .start_i   (w_match),
        .count_o   (w_hold_count_unused),
        .busy_o    (win_o)
    );

    assign detect_o  = r_detect;
    assign timeout_o = r_timeout;
    assign fill_o    = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_compass_seq_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_compass_seq_n
// Brief    : Directed bench; overlapping and non-overlapping instances share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_compass_seq_n;
    import compass_pkg::*;

    localparam int         depth_c   = 4;
    localparam int         timeout_c = 20;
    localparam int         hold_c    = 8;
    localparam logic [7:0] pat_nesw  = 8'b10_11_01_00;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid;
    logic       load;
    logic [1:0] direction;
    logic [7:0] pattern;

    logic       det_ov, win_ov, tmo_ov;
    logic       det_no, win_no, tmo_no;
    logic [2:0] fill_ov, fill_no;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_det_ov, cnt_det_no, cnt_win_ov, cnt_tmo;

    always #5 clk = ~clk;

    compass_seq_n #(
        .depth_p(depth_c), .timeout_p(timeout_c), .hold_p(hold_c),
        .overlap_p(1), .pattern_reset_p(8'h00)
    ) dut_ov (
        .clk_i(clk), .reset_n_i(reset_n), .direction_i(direction), .valid_i(valid),
        .load_i(load), .pattern_i(pattern), .detect_o(det_ov), .win_o(win_ov),
        .fill_o(fill_ov), .timeout_o(tmo_ov)
    );

    compass_seq_n #(
        .depth_p(depth_c), .timeout_p(timeout_c), .hold_p(hold_c),
        .overlap_p(0), .pattern_reset_p(8'h00)
    ) dut_no (
        .clk_i(clk), .reset_n_i(reset_n), .direction_i(direction), .valid_i(valid),
        .load_i(load), .pattern_i(pattern), .detect_o(det_no), .win_o(win_no),
        .fill_o(fill_no), .timeout_o(tmo_no)
    );

    typedef struct {
        logic       ld;
        logic       vld;
        logic [1:0] dir;
        logic       det;
        logic       win;
        logic [2:0] fo;
        logic [2:0] fn;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ld, input logic vld, input logic [1:0] dir,
                                input logic det, input logic win, input int fo, input int fn,
                                input logic tmo);
        vec_t v;
        v.ld = ld; v.vld = vld; v.dir = dir; v.det = det; v.win = win;
        v.fo = 3'(fo); v.fn = 3'(fn); v.tmo = tmo;
        vecs.push_back(v);
    endfunction

    function automatic void idles(input int n, input logic win, input int fo, input int fn);
        for (int k = 0; k < n; k++) add(1'b0, 1'b0, N, 1'b0, win, fo, fn, 1'b0);
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cnt_det_ov += int'(det_ov);
        cnt_det_no += int'(det_no);
        cnt_win_ov += int'(win_ov);
        cnt_tmo    += int'(tmo_ov) + int'(tmo_no);
    endtask

    task automatic enter(input logic [1:0] dir);
        direction = dir;
        valid     = 1'b1;
        tick();
        valid     = 1'b0;
    endtask

    task automatic do_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic clear_counts();
        cnt_det_ov = 0; cnt_det_no = 0; cnt_win_ov = 0; cnt_tmo = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; valid = 1'b0; load = 1'b0; direction = N; pattern = pat_nesw;
        clear_counts();

        // single-cycle vectors: {load, valid, dir, detect, win, fill_ov, fill_no, timeout}
        add(1, 0, N, 0, 0, 0, 0, 0);
        add(0, 1, N, 0, 0, 1, 1, 0); idles(3, 0, 1, 1);
        add(0, 1, E, 0, 0, 2, 2, 0); idles(3, 0, 2, 2);
        add(0, 1, S, 0, 0, 3, 3, 0); idles(3, 0, 3, 3);
        add(0, 1, W, 1, 1, 4, 0, 0); idles(7, 1, 4, 0); idles(1, 0, 4, 0);
        add(1, 0, N, 0, 0, 0, 0, 0);
        add(0, 1, N, 0, 0, 1, 1, 0);
        add(0, 1, E, 0, 0, 2, 2, 0);
        add(0, 1, S, 0, 0, 3, 3, 0);
        add(1, 1, W, 0, 0, 0, 0, 0); idles(1, 0, 0, 0);
        add(0, 1, E, 0, 0, 1, 1, 0);
        add(0, 1, N, 0, 0, 2, 2, 0);
        add(0, 1, E, 0, 0, 3, 3, 0);
        add(0, 1, S, 0, 0, 4, 4, 0);
        add(0, 1, W, 1, 1, 4, 0, 0);
        add(0, 1, N, 0, 1, 4, 1, 0);
        add(0, 1, E, 0, 1, 4, 2, 0);
        add(0, 1, S, 0, 1, 4, 3, 0);
        add(0, 1, N, 0, 1, 4, 4, 0);
        add(1, 0, N, 0, 1, 0, 0, 0); idles(2, 1, 0, 0); idles(1, 0, 0, 0);
        add(0, 1, N, 0, 0, 1, 1, 0);
        add(0, 1, E, 0, 0, 2, 2, 0); idles(19, 0, 2, 2);
        add(0, 0, N, 0, 0, 0, 0, 1);

        repeat (3) tick();
        check("reset detect_ov", det_ov, 0);
        check("reset detect_no", det_no, 0);
        check("reset win_ov", win_ov, 0);
        check("reset win_no", win_no, 0);
        check("reset fill_ov", fill_ov, 0);
        check("reset fill_no", fill_no, 0);
        check("reset timeout_ov", tmo_ov, 0);
        check("reset timeout_no", tmo_no, 0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            load = vecs[i].ld; valid = vecs[i].vld; direction = vecs[i].dir;
            tick();
            check($sformatf("v%0d detect_ov", i), det_ov, vecs[i].det);
            check($sformatf("v%0d detect_no", i), det_no, vecs[i].det);
            check($sformatf("v%0d win_ov", i), win_ov, vecs[i].win);
            check($sformatf("v%0d win_no", i), win_no, vecs[i].win);
            check($sformatf("v%0d fill_ov", i), fill_ov, vecs[i].fo);
            check($sformatf("v%0d fill_no", i), fill_no, vecs[i].fn);
            check($sformatf("v%0d timeout_ov", i), tmo_ov, vecs[i].tmo);
            check($sformatf("v%0d timeout_no", i), tmo_no, vecs[i].tmo);
        end
        load = 1'b0; valid = 1'b0;

        // history already empty: a long idle stretch must stay silent
        clear_counts();
        repeat (40) tick();
        check("idle no second timeout", cnt_tmo, 0);
        check("idle fill_ov", fill_ov, 0);
        check("idle fill_no", fill_no, 0);

        // back-to-back NESWNESW: two detects, win retriggered without a gap
        do_load();
        clear_counts();
        enter(N); enter(E); enter(S); enter(W);
        enter(N); enter(E); enter(S); enter(W);
        repeat (30) tick();
        check("double detect_ov count", cnt_det_ov, 2);
        check("double detect_no count", cnt_det_no, 2);
        check("retrigger win cycles", cnt_win_ov, 12);

        // NESWESW: trailing W,E,S,W never forms the pattern
        do_load();
        clear_counts();
        enter(N); enter(E); enter(S); enter(W);
        enter(E); enter(S); enter(W);
        repeat (2) tick();
        check("nesw-esw detect_ov count", cnt_det_ov, 1);
        check("nesw-esw detect_no count", cnt_det_no, 1);

        // reset during the third cycle of win_o
        do_load();
        enter(N); enter(E); enter(S); enter(W);
        tick(); tick();
        check("pre-reset win_ov", win_ov, 1);
        check("pre-reset fill_ov", fill_ov, 4);
        reset_n = 1'b0;
        #1;
        check("async reset win_ov", win_ov, 0);
        check("async reset win_no", win_no, 0);
        check("async reset fill_ov", fill_ov, 0);
        check("async reset detect_ov", det_ov, 0);
        check("async reset detect_no", det_no, 0);
        repeat (2) tick();
        reset_n = 1'b1;

        // pattern is back at its reset value NNNN; a fifth N only re-matches with overlap
        enter(N); enter(N); enter(N); enter(N);
        check("reset pattern detect_ov", det_ov, 1);
        check("reset pattern detect_no", det_no, 1);
        check("reset pattern win_ov", win_ov, 1);
        enter(N);
        check("overlap fifth N detect_ov", det_ov, 1);
        check("overlap fifth N detect_no", det_no, 0);
        check("overlap fifth N fill_no", fill_no, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
